// File: rtl/bonus_ship_hit_score.sv
// Bonus-ship kill scoring: awards a shot-count-dependent mystery value,
// latches the explosion position and times the explosion animation.
module bonus_ship_hit_score #(
  parameter int SHIP_Y          = 64,
  parameter int EXPLOSION_WIDTH = 32,
  parameter int EXPLODE_FRAMES  = 48,
  parameter int FRAMES_PER_STEP = 12,
  parameter int SCREEN_W        = 640
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               playGame,
  input  logic               shipAlive,
  input  logic signed [10:0] shipTopLeftX,
  input  logic               bonusFireCollision,
  input  logic               playerShotFired,
  output logic               scoreAdd,
  output logic [8:0]         scoreValue,
  output logic               explosionActive,
  output logic signed [10:0] explosionTopLeftX,
  output logic signed [10:0] explosionTopLeftY,
  output logic [1:0]         explosionFrame,
  output logic [7:0]         hitCount
);

  localparam int                 FW         = $clog2(EXPLODE_FRAMES + 1);
  localparam logic signed [10:0] X_MAX      = 11'(SCREEN_W - EXPLOSION_WIDTH);
  localparam logic [FW-1:0]      FRAME_LAST = FW'(EXPLODE_FRAMES);
  localparam logic [FW-1:0]      FRAME_STEP = FW'(FRAMES_PER_STEP);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    HIT     = 2'd2,
    EXPLODE = 2'd3
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [3:0]         shot_count_r, shot_count_nxt_s;
  logic [FW-1:0]      frame_cnt_r, frame_cnt_nxt_s, frame_inc_s;
  logic               explode_done_s;
  logic               score_add_r, score_add_nxt_s;
  logic [8:0]         score_value_r, score_value_nxt_s;
  logic               active_r, active_nxt_s;
  logic signed [10:0] expl_x_r, expl_x_nxt_s;
  logic [1:0]         anim_r, anim_nxt_s;
  logic [7:0]         hit_count_r, hit_count_nxt_s;

  // 300 for a 15-shot kill, otherwise 50/100/150/200 from the low shot bits
  function automatic logic [8:0] mystery_value(input logic [3:0] shots);
    logic [8:0] v;
    if (shots == 4'd15) v = 9'd300;
    else                v = (9'd50 * {7'd0, shots[1:0]}) + 9'd50;
    return v;
  endfunction

  function automatic logic signed [10:0] clamp_x(input logic signed [10:0] x);
    logic signed [10:0] c;
    if (x < 11'sd0)       c = 11'sd0;
    else if (x > X_MAX)   c = X_MAX;
    else                  c = x;
    return c;
  endfunction

  function automatic logic [1:0] anim_step(input logic [FW-1:0] cnt);
    logic [FW-1:0] q;
    logic [1:0]    r;
    q = cnt / FRAME_STEP;
    if (q > FW'(3)) r = 2'd3;
    else            r = q[1:0];
    return r;
  endfunction

  // Saturating explosion frame increment and end-of-explosion detect
  always_comb begin
    if (frame_cnt_r == FRAME_LAST) frame_inc_s = frame_cnt_r;
    else                           frame_inc_s = frame_cnt_r + FW'(1);
    explode_done_s = startOfFrame && (frame_inc_s == FRAME_LAST);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic; collision wins over the ship leaving in the same cycle
  always_comb begin
    state_nxt_s = state_r;
    if (!playGame) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (shipAlive) state_nxt_s = ARMED;
          else           state_nxt_s = IDLE;
        end
        ARMED: begin
          if (bonusFireCollision) state_nxt_s = HIT;
          else if (!shipAlive)    state_nxt_s = IDLE;
          else                    state_nxt_s = ARMED;
        end
        HIT:     state_nxt_s = EXPLODE;
        EXPLODE: begin
          if (explode_done_s) state_nxt_s = IDLE;
          else                state_nxt_s = EXPLODE;
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Output/datapath next values; the award is loaded on the ARMED->HIT edge
  always_comb begin
    score_add_nxt_s   = 1'b0;
    score_value_nxt_s = score_value_r;
    hit_count_nxt_s   = hit_count_r;
    expl_x_nxt_s      = expl_x_r;
    active_nxt_s      = active_r;
    anim_nxt_s        = anim_r;
    frame_cnt_nxt_s   = frame_cnt_r;
    shot_count_nxt_s  = shot_count_r;
    if (!playGame) begin
      shot_count_nxt_s = 4'd0;
      active_nxt_s     = 1'b0;
      anim_nxt_s       = 2'd0;
      frame_cnt_nxt_s  = {FW{1'b0}};
    end else begin
      if (playerShotFired) shot_count_nxt_s = shot_count_r + 4'd1;
      else                 shot_count_nxt_s = shot_count_r;
      case (state_r)
        ARMED: begin
          if (bonusFireCollision) begin
            score_add_nxt_s   = 1'b1;
            score_value_nxt_s = mystery_value(shot_count_r);
            if (hit_count_r == 8'd255) hit_count_nxt_s = hit_count_r;
            else                       hit_count_nxt_s = hit_count_r + 8'd1;
            expl_x_nxt_s      = clamp_x(shipTopLeftX);
            active_nxt_s      = 1'b1;
            anim_nxt_s        = 2'd0;
            frame_cnt_nxt_s   = {FW{1'b0}};
          end else begin
            active_nxt_s = 1'b0;
          end
        end
        EXPLODE: begin
          if (startOfFrame) begin
            frame_cnt_nxt_s = frame_inc_s;
            if (explode_done_s) begin
              active_nxt_s = 1'b0;
              anim_nxt_s   = 2'd0;
            end else begin
              anim_nxt_s = anim_step(frame_inc_s);
            end
          end else begin
            frame_cnt_nxt_s = frame_cnt_r;
          end
        end
        default: begin
          frame_cnt_nxt_s = frame_cnt_r;
        end
      endcase
    end
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shot_count_r  <= 4'd0;
      frame_cnt_r   <= {FW{1'b0}};
      score_add_r   <= 1'b0;
      score_value_r <= 9'd0;
      active_r      <= 1'b0;
      expl_x_r      <= 11'sd0;
      anim_r        <= 2'd0;
      hit_count_r   <= 8'd0;
    end else begin
      shot_count_r  <= shot_count_nxt_s;
      frame_cnt_r   <= frame_cnt_nxt_s;
      score_add_r   <= score_add_nxt_s;
      score_value_r <= score_value_nxt_s;
      active_r      <= active_nxt_s;
      expl_x_r      <= expl_x_nxt_s;
      anim_r        <= anim_nxt_s;
      hit_count_r   <= hit_count_nxt_s;
    end
  end

  assign scoreAdd          = score_add_r;
  assign scoreValue        = score_value_r;
  assign explosionActive   = active_r;
  assign explosionTopLeftX = expl_x_r;
  assign explosionTopLeftY = 11'(SHIP_Y);
  assign explosionFrame    = anim_r;
  assign hitCount          = hit_count_r;

endmodule

// File: tb/tb_bonus_ship_hit_score.sv
// Self-checking bench for bonus_ship_hit_score: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_bonus_ship_hit_score;

  logic               clk = 1'b0;
  logic               reset;
  logic               startOfFrame, playGame, shipAlive;
  logic signed [10:0] shipTopLeftX;
  logic               bonusFireCollision, playerShotFired;
  logic               scoreAdd;
  logic [8:0]         scoreValue;
  logic               explosionActive;
  logic signed [10:0] explosionTopLeftX, explosionTopLeftY;
  logic [1:0]         explosionFrame;
  logic [7:0]         hitCount;

  int n_checks = 0;
  int n_fail   = 0;

  // model of the game rules
  int                 m_shots, m_frames;
  bit                 m_armed, m_fresh, m_add, m_active;
  logic [8:0]         m_value;
  logic signed [10:0] m_x;
  logic [1:0]         m_frame;
  logic [7:0]         m_hit;

  bonus_ship_hit_score dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .playGame(playGame),
    .shipAlive(shipAlive), .shipTopLeftX(shipTopLeftX),
    .bonusFireCollision(bonusFireCollision), .playerShotFired(playerShotFired),
    .scoreAdd(scoreAdd), .scoreValue(scoreValue), .explosionActive(explosionActive),
    .explosionTopLeftX(explosionTopLeftX), .explosionTopLeftY(explosionTopLeftY),
    .explosionFrame(explosionFrame), .hitCount(hitCount)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_shots = 0; m_frames = -1; m_armed = 1'b0; m_fresh = 1'b0;
    m_add = 1'b0; m_active = 1'b0; m_value = 9'd0; m_x = 11'sd0;
    m_frame = 2'd0; m_hit = 8'd0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic step(input bit sof, input bit play, input bit alive,
                      input bit coll, input bit shot, input int x);
    int old_shots;
    int cx;
    startOfFrame = sof; playGame = play; shipAlive = alive;
    bonusFireCollision = coll; playerShotFired = shot; shipTopLeftX = 11'(x);
    @(posedge clk);
    m_add = 1'b0;
    if (!play) begin
      m_armed = 1'b0; m_fresh = 1'b0; m_frames = -1; m_shots = 0; m_active = 1'b0;
    end else begin
      old_shots = m_shots;
      if (shot) m_shots = (m_shots + 1) % 16;
      if (m_fresh) begin
        m_fresh = 1'b0; m_frames = 0;
      end else if (m_frames >= 0) begin
        if (sof) begin
          m_frames = m_frames + 1;
          if (m_frames >= 48) begin
            m_frames = -1; m_active = 1'b0;
          end else begin
            m_frame = 2'((m_frames / 12 > 3) ? 3 : m_frames / 12);
          end
        end
      end else if (!m_armed) begin
        m_armed = alive;
      end else if (coll) begin
        cx = (x < 0) ? 0 : ((x > 608) ? 608 : x);
        m_armed = 1'b0; m_fresh = 1'b1; m_add = 1'b1; m_active = 1'b1; m_frame = 2'd0;
        m_value = (old_shots == 15) ? 9'd300 : 9'(50 * ((old_shots % 4) + 1));
        m_x = 11'(cx);
        m_hit = (m_hit == 8'd255) ? 8'd255 : m_hit + 8'd1;
      end else if (!alive) begin
        m_armed = 1'b0;
      end
    end
    #1;
  endtask

  task automatic flush();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    startOfFrame = 1'b0; playGame = 1'b0; shipAlive = 1'b0; shipTopLeftX = 11'sd0;
    bonusFireCollision = 1'b0; playerShotFired = 1'b0;
    model_reset();
    #12;
    n_checks++;
    if ({scoreAdd, scoreValue, explosionActive, explosionTopLeftX, explosionFrame, hitCount} !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: add=%0b val=%0d act=%0b x=%0d frm=%0d hit=%0d, all must be 0",
               scoreAdd, scoreValue, explosionActive, explosionTopLeftX, explosionFrame, hitCount);
    end
    n_checks++;
    if (explosionTopLeftY !== 11'sd64) begin
      n_fail++; $display("FAIL reset_y: got %0d want 64", explosionTopLeftY);
    end
    @(negedge clk); reset = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    n_checks++;
    if (scoreAdd !== 1'b0 || explosionActive !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: add=%0b act=%0b want 0 0", scoreAdd, explosionActive);
    end
  endtask

  task automatic test_value_100();
    flush();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 200);
    n_checks++;
    if (scoreAdd !== 1'b0) begin n_fail++; $display("FAIL v100_early: scoreAdd=%0b want 0", scoreAdd); end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 200);
    n_checks++;
    if (scoreAdd !== 1'b1 || scoreValue !== 9'd100) begin
      n_fail++; $display("FAIL v100_award: add=%0b val=%0d want 1 100", scoreAdd, scoreValue);
    end
    n_checks++;
    if (explosionTopLeftX !== 11'sd200 || explosionTopLeftY !== 11'sd64 || hitCount !== 8'd1) begin
      n_fail++; $display("FAIL v100_pos: x=%0d y=%0d hit=%0d want 200 64 1",
                         explosionTopLeftX, explosionTopLeftY, hitCount);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 200);
    n_checks++;
    if (scoreAdd !== 1'b0 || scoreValue !== 9'd100) begin
      n_fail++; $display("FAIL v100_pulse: add=%0b val=%0d want 0 100", scoreAdd, scoreValue);
    end
  endtask

  task automatic test_value_300();
    flush();
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 100);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 100);
    n_checks++;
    if (scoreAdd !== 1'b1 || scoreValue !== 9'd300) begin
      n_fail++; $display("FAIL v300_award: add=%0b val=%0d want 1 300", scoreAdd, scoreValue);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    for (int k = 0; k < 48; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    n_checks++;
    if (explosionActive !== 1'b0) begin
      n_fail++; $display("FAIL v300_explode_end: act=%0b want 0", explosionActive);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 100);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 100);
    n_checks++;
    if (scoreAdd !== 1'b1 || scoreValue !== 9'd50) begin
      n_fail++; $display("FAIL v300_wrap: add=%0b val=%0d want 1 50", scoreAdd, scoreValue);
    end
  endtask

  task automatic test_clamp();
    int xs[7]   = '{630, -10, 608, 0, 609, -1024, 1023};
    int want[7] = '{608, 0, 608, 0, 608, 0, 608};
    for (int i = 0; i < 7; i++) begin
      flush();
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, xs[i]);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, xs[i]);
      n_checks++;
      if (explosionTopLeftX !== 11'(want[i]) || scoreAdd !== 1'b1) begin
        n_fail++; $display("FAIL clamp_x: in=%0d got %0d add=%0b want %0d 1",
                           xs[i], explosionTopLeftX, scoreAdd, want[i]);
      end
    end
  endtask

  task automatic test_hold_and_animation();
    int adds;
    int ef;
    flush();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 300);
    adds = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 300);
      if (scoreAdd === 1'b1) adds++;
    end
    n_checks++;
    if (adds != 1 || explosionActive !== 1'b1 || explosionFrame !== 2'd0) begin
      n_fail++; $display("FAIL hold_single_award: adds=%0d act=%0b frm=%0d want 1 1 0",
                         adds, explosionActive, explosionFrame);
    end
    for (int k = 1; k <= 48; k++) begin
      step(1'b1, 1'b1, 1'b1, (k % 5) == 0, 1'b0, 300);
      ef = (k / 12 > 3) ? 3 : k / 12;
      n_checks++;
      if (k < 48) begin
        if (explosionActive !== 1'b1 || explosionFrame !== 2'(ef) || scoreAdd !== 1'b0) begin
          n_fail++; $display("FAIL anim_step: pulse=%0d act=%0b frm=%0d add=%0b want 1 %0d 0",
                             k, explosionActive, explosionFrame, scoreAdd, ef);
        end
      end else begin
        if (explosionActive !== 1'b0) begin
          n_fail++; $display("FAIL anim_end: pulse=48 act=%0b want 0", explosionActive);
        end
      end
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 300);
    n_checks++;
    if (scoreAdd !== 1'b0) begin n_fail++; $display("FAIL rearm_delay: add=%0b want 0", scoreAdd); end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 300);
    n_checks++;
    if (scoreAdd !== 1'b1) begin n_fail++; $display("FAIL rearm_award: add=%0b want 1", scoreAdd); end
  endtask

  task automatic test_leave_and_pause();
    logic [7:0] hit_before;
    flush();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 50);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 50);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 50);
    n_checks++;
    if (scoreAdd !== 1'b0 || explosionActive !== 1'b0) begin
      n_fail++; $display("FAIL ship_left: add=%0b act=%0b want 0 0", scoreAdd, explosionActive);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 50);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 50);
    n_checks++;
    if (scoreValue !== 9'd200) begin n_fail++; $display("FAIL val_200: got %0d want 200", scoreValue); end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    hit_before = hitCount;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    n_checks++;
    if (explosionActive !== 1'b0 || scoreValue !== 9'd200 || hitCount !== m_hit) begin
      n_fail++; $display("FAIL pause: act=%0b val=%0d hit=%0d want 0 200 %0d (was %0d)",
                         explosionActive, scoreValue, hitCount, m_hit, hit_before);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 50);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 50);
    n_checks++;
    if (scoreAdd !== 1'b1 || scoreValue !== 9'd50) begin
      n_fail++; $display("FAIL pause_shots_clear: add=%0b val=%0d want 1 50", scoreAdd, scoreValue);
    end
  endtask

  task automatic test_reset_mid_explode();
    flush();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 320);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 320);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    n_checks++;
    if (explosionActive !== 1'b1 || explosionFrame !== 2'd1) begin
      n_fail++; $display("FAIL mid_explode: act=%0b frm=%0d want 1 1", explosionActive, explosionFrame);
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({scoreAdd, scoreValue, explosionActive, explosionTopLeftX, explosionFrame, hitCount} !== 32'd0
        || explosionTopLeftY !== 11'sd64) begin
      n_fail++; $display("FAIL async_reset: add=%0b val=%0d act=%0b x=%0d frm=%0d hit=%0d y=%0d want 0s y=64",
                         scoreAdd, scoreValue, explosionActive, explosionTopLeftX,
                         explosionFrame, hitCount, explosionTopLeftY);
    end
    @(negedge clk); reset = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    n_checks++;
    if (scoreAdd !== 1'b0 || explosionActive !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: add=%0b act=%0b want 0 0", scoreAdd, explosionActive);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10);
    n_checks++;
    if (scoreAdd !== 1'b1 || scoreValue !== 9'd50 || hitCount !== 8'd1) begin
      n_fail++; $display("FAIL post_reset_kill: add=%0b val=%0d hit=%0d want 1 50 1",
                         scoreAdd, scoreValue, hitCount);
    end
  endtask

  task automatic test_random();
    bit alive;
    alive = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(19) == 0) alive = ~alive;
      step($urandom_range(2) == 0, $urandom_range(199) != 0, alive,
           $urandom_range(5) == 0, $urandom_range(3) == 0, int'($urandom_range(750)) - 50);
      n_checks++;
      if (scoreAdd !== m_add || scoreValue !== m_value || explosionActive !== m_active
          || hitCount !== m_hit || (m_active && (explosionTopLeftX !== m_x || explosionFrame !== m_frame))) begin
        n_fail++;
        $display("FAIL random_cycle %0d: add=%0b/%0b val=%0d/%0d act=%0b/%0b hit=%0d/%0d x=%0d/%0d frm=%0d/%0d (got/want)",
                 c, scoreAdd, m_add, scoreValue, m_value, explosionActive, m_active,
                 hitCount, m_hit, explosionTopLeftX, m_x, explosionFrame, m_frame);
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 270; i++) begin
      flush();
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
      n_checks++;
      if (hitCount !== m_hit || scoreAdd !== 1'b1) begin
        n_fail++; $display("FAIL sat_kill %0d: hit=%0d add=%0b want %0d 1", i, hitCount, scoreAdd, m_hit);
      end
    end
    n_checks++;
    if (hitCount !== 8'd255) begin n_fail++; $display("FAIL sat_final: hit=%0d want 255", hitCount); end
  endtask

  initial begin
    test_reset();
    test_value_100();
    test_value_300();
    test_clamp();
    test_hold_and_animation();
    test_leave_and_pause();
    test_reset_mid_explode();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bonus_ship_hit_score.md
Name: bonus_ship_hit_score

Overview:
- Sits directly downstream of the bonus-ship movement/collision stage.
- Consumes that stage's alive flag, topLeftX and the same bonusFireCollision pulse, and turns a bonus-ship kill into three things:
  - a one-cycle score award with a shot-count-dependent mystery value;
  - a latched explosion sprite position;
  - a frame-timed explosion animation for the drawing/priority mux.
- Also counts player shots to seed the mystery value.

Parameters:
- SHIP_Y, 64: fixed Y of bonus ship row; copied to explosionTopLeftY.
- EXPLOSION_WIDTH, 32: sprite width used for right-edge clamp.
- EXPLODE_FRAMES, 48: startOfFrame pulses the explosion lasts.
- FRAMES_PER_STEP, 12: startOfFrame pulses per animation step.
- SCREEN_W, 640: visible width in pixels.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- startOfFrame, in, 1: one-cycle pulse per video frame.
- playGame, in, 1: low = game not running; sampled synchronously.
- shipAlive, in, 1: bonus ship alive from the movement stage.
- shipTopLeftX, in, 11 signed: bonus ship X from the movement stage.
- bonusFireCollision, in, 1: player shot hit bonus ship (pulse or level).
- playerShotFired, in, 1: one-cycle pulse per player shot launched.
- scoreAdd, out, 1: one-cycle pulse; add scoreValue to score.
- scoreValue, out, 9: awarded points, held until next hit.
- explosionActive, out, 1: explosion sprite enable.
- explosionTopLeftX, out, 11 signed: clamped explosion X.
- explosionTopLeftY, out, 11 signed: equals SHIP_Y.
- explosionFrame, out, 2: animation index 0..3.
- hitCount, out, 8: total bonus kills, saturating.

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; shotCount=0; explosionTopLeftY=SHIP_Y.
- playGame=0 (synchronous, checked first every cycle): state IDLE, explosionActive=0, scoreAdd=0, shotCount=0. scoreValue and hitCount are held.
- shotCount: 4-bit; +1 on each playerShotFired while playGame=1; wraps 15->0.
- FSM states: IDLE, ARMED, HIT, EXPLODE.
- IDLE -> ARMED when shipAlive=1.
- ARMED -> IDLE when shipAlive=0 and bonusFireCollision=0 (ship left screen); no award in this case.
- ARMED -> HIT when bonusFireCollision=1. Collision takes priority over shipAlive falling in the same cycle. On this edge:
  - latch value from shotCount as it was before any same-cycle increment: 300 if shotCount==15, else 50*(shotCount[1:0]+1), i.e. 50/100/150/200;
  - latch explosionTopLeftX = clamp(shipTopLeftX, 0, SCREEN_W-EXPLOSION_WIDTH), signed compare, so negative X gives 0;
  - clear frameCnt.
- HIT lasts exactly 1 cycle:
  - scoreAdd=1, scoreValue updated, hitCount +1 saturating at 255, explosionActive=1, explosionFrame=0;
  - next state EXPLODE.
- Latency: collision sampled at cycle t -> scoreAdd high at t+1 only.
- EXPLODE:
  - frameCnt +1 on each startOfFrame;
  - explosionFrame = min(frameCnt/FRAMES_PER_STEP, 3);
  - when frameCnt reaches EXPLODE_FRAMES (incrementing pulse), go to IDLE with explosionActive=0 the next cycle.
- bonusFireCollision in HIT or EXPLODE is ignored: no re-award for multi-cycle collision levels.
- shipAlive=1 during EXPLODE (a new ship already spawned) is not armed until the explosion finishes. Back in IDLE it arms on the next cycle if still alive.
- frameCnt width must hold EXPLODE_FRAMES; saturates, never wraps.
- scoreAdd is never high for more than 1 consecutive cycle.

Test Plan:
- Reset mid-EXPLODE (frameCnt=20): assert reset -> all outputs 0 immediately (async); after release, state IDLE and no scoreAdd.
- 5 playerShotFired pulses, shipAlive=1, shipTopLeftX=200, collision pulse -> scoreAdd one cycle later for 1 cycle; scoreValue=100 (shotCount=5, [1:0]=1); explosionTopLeftX=200, Y=64; hitCount=1.
- 15 shots, collision in same cycle as 16th shot -> scoreValue=300; shotCount then 0.
- shipTopLeftX=630 collision -> explosionTopLeftX=608; shipTopLeftX=-10 -> 0.
- Collision held high 10 cycles -> exactly one scoreAdd. Feed 48 startOfFrame -> explosionFrame steps 0,1,2,3 at pulses 0/12/24/36; explosionActive falls after pulse 48.
- shipAlive 1->0 with no collision -> no scoreAdd, state IDLE. playGame dropped mid-EXPLODE -> explosionActive=0 next cycle, shotCount=0.
